// File: rtl/y86_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : y86_mem_arbiter
// Description : Shares one single-port 32-bit memory between the two-beat
//               instruction fetch port and the one-beat data port, with fair
//               priority, fetch beat sequencing and a per-beat timeout.
//               Optional one-entry fetch buffer: define Y86_FETCH_BUF_EN.
// Revision    : 1.0
// =============================================================================
module y86_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic [47:0] f_inst_o,
    output logic        f_done_o,
    output logic        f_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_done_o,
    output logic        d_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA  = 3'd1,
        S_F_B0  = 3'd2,
        S_F_GAP = 3'd3,
        S_F_B1  = 3'd4
    } state_t;

    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_stateNext;
    logic        r_lastD, w_lastDNext;
    logic [7:0]  r_timer, w_timerNext;
    logic [31:0] r_instHi, w_instHiNext;

    logic        w_memReqNext, w_memWeNext;
    logic [31:0] w_memAddrNext, w_memWdataNext, w_dRdataNext;
    logic [47:0] w_fInstNext;
    logic        w_fDoneNext, w_fErrNext, w_dDoneNext, w_dErrNext;

    logic        w_fWin, w_dWin, w_beatActive, w_timeoutAbort;
    logic        w_bufHit;
    logic [47:0] w_bufInst;

    // A requester whose done pulse is still visible is not re-granted this cycle.
    assign w_fWin = f_req_i && !f_done_o;
    assign w_dWin = d_req_i && !d_done_o;

    assign w_beatActive   = (r_state == S_DATA) || (r_state == S_F_B0) || (r_state == S_F_B1);
    assign w_timeoutAbort = w_beatActive && !mem_ack_i && (r_timer == c_TIMER_LAST);

`ifdef Y86_FETCH_BUF_EN
    logic        r_bufValid;
    logic [31:0] r_bufAddr;
    logic [47:0] r_bufInst;
    logic        w_bufFill, w_bufClear;

    assign w_bufHit   = r_bufValid && (r_bufAddr == f_addr_i);
    assign w_bufInst  = r_bufInst;
    assign w_bufFill  = (r_state == S_F_B1) && mem_ack_i;
    assign w_bufClear = w_timeoutAbort || ((r_state == S_DATA) && mem_ack_i && mem_we_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bufValid <= 1'b0;
            r_bufAddr  <= '0;
            r_bufInst  <= '0;
        end else if (w_bufClear) begin
            r_bufValid <= 1'b0;
        end else if (w_bufFill) begin
            r_bufValid <= 1'b1;
            r_bufAddr  <= f_addr_i;
            r_bufInst  <= w_fInstNext;
        end
    end
`else
    assign w_bufHit  = 1'b0;
    assign w_bufInst = '0;
`endif

    always_comb begin
        w_stateNext    = r_state;
        w_lastDNext    = r_lastD;
        w_timerNext    = r_timer;
        w_instHiNext   = r_instHi;
        w_memReqNext   = mem_req_o;
        w_memWeNext    = mem_we_o;
        w_memAddrNext  = mem_addr_o;
        w_memWdataNext = mem_wdata_o;
        w_dRdataNext   = d_rdata_o;
        w_fInstNext    = f_inst_o;
        w_fDoneNext    = 1'b0;
        w_fErrNext     = 1'b0;
        w_dDoneNext    = 1'b0;
        w_dErrNext     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_timerNext = '0;
                if (w_fWin && (!w_dWin || r_lastD)) begin
                    if (w_bufHit) begin
                        w_fInstNext = w_bufInst;
                        w_fDoneNext = 1'b1;
                    end else begin
                        w_stateNext   = S_F_B0;
                        w_memReqNext  = 1'b1;
                        w_memWeNext   = 1'b0;
                        w_memAddrNext = f_addr_i;
                    end
                end else if (w_dWin) begin
                    w_stateNext    = S_DATA;
                    w_memReqNext   = 1'b1;
                    w_memWeNext    = d_we_i;
                    w_memAddrNext  = d_addr_i;
                    w_memWdataNext = d_wdata_i;
                end
            end
            S_DATA: begin
                if (mem_ack_i) begin
                    w_memReqNext = 1'b0;
                    if (!mem_we_o) begin
                        w_dRdataNext = mem_rdata_i;
                    end
                    w_dDoneNext = 1'b1;
                    w_lastDNext = 1'b1;
                    w_stateNext = S_IDLE;
                end else if (w_timeoutAbort) begin
                    w_memReqNext = 1'b0;
                    w_dDoneNext  = 1'b1;
                    w_dErrNext   = 1'b1;
                    w_stateNext  = S_IDLE;
                end else begin
                    w_timerNext = r_timer + 8'd1;
                end
            end
            S_F_B0: begin
                if (mem_ack_i) begin
                    // Little-endian word: lowest address byte lands in the MSB of the instruction.
                    w_instHiNext = {mem_rdata_i[7:0], mem_rdata_i[15:8],
                                    mem_rdata_i[23:16], mem_rdata_i[31:24]};
                    w_memReqNext = 1'b0;
                    w_stateNext  = S_F_GAP;
                end else if (w_timeoutAbort) begin
                    w_memReqNext = 1'b0;
                    w_fDoneNext  = 1'b1;
                    w_fErrNext   = 1'b1;
                    w_stateNext  = S_IDLE;
                end else begin
                    w_timerNext = r_timer + 8'd1;
                end
            end
            S_F_GAP: begin
                w_timerNext   = '0;
                w_memReqNext  = 1'b1;
                w_memWeNext   = 1'b0;
                w_memAddrNext = f_addr_i + 32'd4;
                w_stateNext   = S_F_B1;
            end
            S_F_B1: begin
                if (mem_ack_i) begin
                    w_fInstNext  = {r_instHi, mem_rdata_i[7:0], mem_rdata_i[15:8]};
                    w_memReqNext = 1'b0;
                    w_fDoneNext  = 1'b1;
                    w_lastDNext  = 1'b0;
                    w_stateNext  = S_IDLE;
                end else if (w_timeoutAbort) begin
                    w_memReqNext = 1'b0;
                    w_fDoneNext  = 1'b1;
                    w_fErrNext   = 1'b1;
                    w_stateNext  = S_IDLE;
                end else begin
                    w_timerNext = r_timer + 8'd1;
                end
            end
            default: begin
                w_stateNext  = S_IDLE;
                w_memReqNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lastD     <= 1'b0;
            r_timer     <= '0;
            r_instHi    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            d_rdata_o   <= '0;
            f_inst_o    <= '0;
            f_done_o    <= 1'b0;
            f_err_o     <= 1'b0;
            d_done_o    <= 1'b0;
            d_err_o     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_lastD     <= w_lastDNext;
            r_timer     <= w_timerNext;
            r_instHi    <= w_instHiNext;
            mem_req_o   <= w_memReqNext;
            mem_we_o    <= w_memWeNext;
            mem_addr_o  <= w_memAddrNext;
            mem_wdata_o <= w_memWdataNext;
            d_rdata_o   <= w_dRdataNext;
            f_inst_o    <= w_fInstNext;
            f_done_o    <= w_fDoneNext;
            f_err_o     <= w_fErrNext;
            d_done_o    <= w_dDoneNext;
            d_err_o     <= w_dErrNext;
        end
    end

endmodule
`default_nettype wire
